// File: rtl/fifo_tile_reader_pkg.sv
// fifo_tile_reader_pkg: shared FSM encoding, default widths and a pointer-width helper
package fifo_tile_reader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
  localparam int DATA_W_DEF = 256;
  localparam int CNT_W_DEF = 16;
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fifo_tile_reader_if.sv
// fifo_tile_reader_if: cmd (valid/ready/words), control-FIFO (empty/rd/q) and tagged stream (valid/ready/data/first/last/eot) plus busy/done; slave=reader, master=environment
interface fifo_tile_reader_if import fifo_tile_reader_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic cmd_valid;
  logic cmd_ready;
  logic [CNT_W-1:0] cmd_words;
  logic fifo_empty;
  logic fifo_rd;
  logic [DATA_W-1:0] fifo_q;
  logic m_valid;
  logic m_ready;
  logic [DATA_W-1:0] m_data;
  logic m_first;
  logic m_last;
  logic m_eot;
  logic busy;
  logic done;
  modport slave (
    input cmd_valid, cmd_words, fifo_empty, fifo_q, m_ready,
    output cmd_ready, fifo_rd, m_valid, m_data, m_first, m_last, m_eot, busy, done
  );
  modport master (
    output cmd_valid, cmd_words, fifo_empty, fifo_q, m_ready,
    input cmd_ready, fifo_rd, m_valid, m_data, m_first, m_last, m_eot, busy, done
  );
endinterface

// File: rtl/fifo_tile_reader_skid.sv
// fifo_tile_reader_skid: show-ahead W x DEPTH sync FIFO (clk, rst, wr_i/wd_i in, rd_i pop, rdata_o head or 0 when empty, count_o occupancy)
module fifo_tile_reader_skid import fifo_tile_reader_pkg::*; #(
  parameter int W = DATA_W_DEF,
  parameter int DEPTH = 4,
  localparam int AW = cnt_bits(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_i,
  input  logic [W-1:0] wd_i,
  input  logic rd_i,
  output logic [W-1:0] rdata_o,
  output logic [CW-1:0] count_o
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_rd;
  assign do_rd = rd_i && cnt_q != '0;
  assign rdata_o = (cnt_q != '0) ? mem_q[rp_q] : '0;
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_i) wp_q <= (wp_q == LAST) ? '0 : wp_q + 1'b1;
      if (do_rd) rp_q <= (rp_q == LAST) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr_i) - CW'(do_rd);
    end
  end
  always_ff @(posedge clk) if (wr_i) mem_q[wp_q] <= wd_i;
  always_ff @(posedge clk) if (!rst && wr_i) assert (cnt_q != CW'(DEPTH));
endmodule

// File: rtl/fifo_tile_reader.sv
// fifo_tile_reader: drains cmd_words control-FIFO words into a tile-tagged valid/ready stream at 1 word/clk (clk, rst, bus: cmd/fifo/stream/busy/done)
module fifo_tile_reader import fifo_tile_reader_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TILE_WORDS = 4,
  parameter int RD_LAT = 1,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  fifo_tile_reader_if.slave bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + 2);
  state_e state_q;
  logic [CNT_W-1:0] words_q, issued_q, sent_q, tile_q;
  logic [RD_LAT-1:0] vpipe_q;
  logic wr_q;
  logic [DATA_W-1:0] wd_q;
  logic done_q;
  logic [CW-1:0] buf_cnt;
  logic [IW-1:0] inflight;
  logic [RD_LAT:0] vsh;
  logic [DATA_W-1:0] head;
  logic rd, m_valid, beat, eot, last, first;
  assign inflight = IW'($countones({vpipe_q, wr_q}));
  assign rd = state_q == RUN && !bus.fifo_empty && issued_q < words_q && int'(buf_cnt) + int'(inflight) < BUF_DEPTH;
  assign vsh = {vpipe_q, rd};
  assign m_valid = buf_cnt != '0;
  assign beat = m_valid && bus.m_ready;
  assign eot = m_valid && sent_q == words_q - 1'b1;
  assign last = eot || (m_valid && tile_q == CNT_W'(TILE_WORDS - 1));
  assign first = m_valid && tile_q == '0;
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.fifo_rd = rd;
  assign bus.m_valid = m_valid;
  assign bus.m_data = head;
  assign bus.m_first = first;
  assign bus.m_last = last;
  assign bus.m_eot = eot;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      words_q <= '0;
      issued_q <= '0;
      sent_q <= '0;
      tile_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.cmd_valid) begin
          if (bus.cmd_words == '0) done_q <= 1'b1;
          else begin
            state_q <= RUN;
            words_q <= bus.cmd_words;
            issued_q <= '0;
            sent_q <= '0;
            tile_q <= '0;
          end
        end
      end else begin
        if (rd) issued_q <= issued_q + 1'b1;
        if (rd && issued_q + 1'b1 == words_q) state_q <= DRAIN;
        if (beat) begin
          sent_q <= sent_q + 1'b1;
          tile_q <= last ? '0 : tile_q + 1'b1;
        end
        if (beat && eot) begin
          state_q <= IDLE;
          done_q <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q <= '0;
      wr_q <= 1'b0;
      wd_q <= '0;
    end else begin
      vpipe_q <= vsh[RD_LAT-1:0];
      wr_q <= vpipe_q[RD_LAT-1];
      if (vpipe_q[RD_LAT-1]) wd_q <= bus.fifo_q;
    end
  end
  fifo_tile_reader_skid #(.W(DATA_W), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .wr_i(wr_q),
    .wd_i(wd_q),
    .rd_i(beat),
    .rdata_o(head),
    .count_o(buf_cnt)
  );
endmodule
